// File: rtl/dm_responder.sv
// Data-memory responder: byte-lane writable word memory behind a req/ack handshake
// with a fixed, parameterised response latency and an out-of-range error flag.
module dm_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg;
  logic          we_reg;
  logic [31:2]   addr_reg;
  logic [31:0]   wdata_reg;
  logic [3:0]    be_reg;
  logic [31:0]   rdata_reg;

  logic          accept;
  logic          enter_resp;
  logic          cur_we;
  logic [31:2]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_be;
  logic [AW-1:0] cur_idx;
  logic          cur_oor;
  logic [31:0]   rd_word;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^addr[1:0];
  assign accept = (state_reg == IDLE) && req;

  // With zero wait cycles the commit happens on the accept edge itself, so the
  // live request fields are used; otherwise the latched copy is.
  assign cur_we    = (state_reg == IDLE) ? we          : we_reg;
  assign cur_addr  = (state_reg == IDLE) ? addr[31:2]  : addr_reg;
  assign cur_wdata = (state_reg == IDLE) ? wdata       : wdata_reg;
  assign cur_be    = (state_reg == IDLE) ? be          : be_reg;
  assign cur_idx   = cur_addr[AW+1:2];
  assign cur_oor   = |cur_addr[31:AW+2];

  // Gated by rstn so no edge seen during reset can commit to memory.
  assign enter_resp = rstn && (state_next == RESP);

  always_ff @(posedge clk) begin
    if (accept) begin
      we_reg    <= we;
      addr_reg  <= addr[31:2];
      wdata_reg <= wdata;
      be_reg    <= be;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      if (accept && (state_next == WAIT)) begin
        cnt_reg <= CNT_INIT;
      end else if ((state_reg == WAIT) && (cnt_reg != 4'd0)) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req) state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT:    if (cnt_reg == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ack  = (state_reg == RESP);
    err  = (state_reg == RESP) && cur_oor;
    busy = (state_reg != IDLE);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !cur_oor && cur_be[gi]) begin
          mem[cur_idx] <= cur_wdata[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = mem[cur_idx];
    end
  endgenerate

  // Read data is captured once per read ack and then held; writes never touch it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_reg <= 32'd0;
    end else if (enter_resp && !cur_we) begin
      rdata_reg <= cur_oor ? 32'd0 : rd_word;
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: three instances (0, 1 and 3 wait cycles) share one stimulus
// stream; a per-instance monitor checks every ack against a queued reference result.
module tb_dm_responder;

  localparam int NDUT = 3;

  logic        clk, rstn, req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [31:0] rdata_w [NDUT];
  logic        ack_w   [NDUT];
  logic        err_w   [NDUT];
  logic        busy_w  [NDUT];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q   [NDUT][$];
  logic [31:0] mm      [NDUT][16];
  logic [31:0] last_rd [NDUT];

  function automatic int wc_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 3;
  endfunction

  task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, d, cyc, act, want);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      localparam int WC = (gi == 0) ? 0 : (gi == 1) ? 1 : 3;
      exp_t e;

      dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WC)) u_dut (
        .clk   (clk),
        .rstn  (rstn),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .be    (be),
        .rdata (rdata_w[gi]),
        .ack   (ack_w[gi]),
        .err   (err_w[gi]),
        .busy  (busy_w[gi])
      );

      always @(negedge clk) begin
        if (ack_w[gi]) begin
          if (exp_q[gi].size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_ack dut%0d cyc=%0d got=1 want=0", gi, cyc);
          end else begin
            e = exp_q[gi].pop_front();
            $display("dut%0d ack cyc=%0d err=%0b rdata=%h", gi, cyc, err_w[gi], rdata_w[gi]);
            check("ack_cycle", gi, 32'(cyc), 32'(e.cyc));
            check("ack_err", gi, {31'd0, err_w[gi]}, {31'd0, e.err});
            check("ack_rdata", gi, rdata_w[gi], e.rdata);
          end
        end else begin
          check("err_without_ack", gi, {31'd0, err_w[gi]}, 32'd0);
        end
      end
    end
  endgenerate

  // Reference: word-addressed store of the 16 tracked words, byte lanes merged per be.
  task automatic model_push(input int i, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b, input int acc_cyc);
    exp_t e;
    logic oor;
    int   idx;
    oor   = (a[31:12] != 20'd0);
    idx   = int'(a[5:2]);
    e.cyc = acc_cyc + 1 + wc_of(i);
    e.err = oor;
    if (!w) begin
      last_rd[i] = oor ? 32'd0 : mm[i][idx];
    end else if (!oor) begin
      for (int k = 0; k < 4; k++)
        if (b[k]) mm[i][idx][8*k +: 8] = d[8*k +: 8];
    end
    e.rdata = last_rd[i];
    exp_q[i].push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 30) begin
      bad++;
      $display("FAIL ack_timeout pending=%0d/%0d/%0d want=0", exp_q[0].size(), exp_q[1].size(), exp_q[2].size());
      for (int i = 0; i < NDUT; i++) exp_q[i].delete();
    end
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) check("busy_after_ack", i, {31'd0, busy_w[i]}, 32'd0);
  endtask

  // Called at a falling edge; the next rising edge is the accept edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input bit poke);
    int c;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    c = cyc;
    for (int i = 0; i < NDUT; i++) model_push(i, w, a, d, b, c);
    @(negedge clk);
    req = poke;
    we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
    for (int i = 0; i < NDUT; i++) check("busy_after_accept", i, {31'd0, busy_w[i]}, 32'd1);
    if (poke) begin
      @(negedge clk);
      req = 1'b0;
    end
    wait_idle();
  endtask

  task automatic stream(input int n);
    int c;
    req = 1'b1; we = 1'b0; addr = 32'h10; wdata = 32'd0; be = 4'd0;
    c = cyc;
    for (int i = 0; i < NDUT; i++)
      for (int t = c; t < c + n; t += wc_of(i) + 2)
        model_push(i, 1'b0, 32'h10, 32'd0, 4'd0, t);
    repeat (n) @(negedge clk);
    req = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        w, oor;
    logic [31:0] a;
    int          idx;

    rstn = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
    for (int i = 0; i < NDUT; i++) last_rd[i] = 32'd0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check("reset_ack", i, {31'd0, ack_w[i]}, 32'd0);
      check("reset_err", i, {31'd0, err_w[i]}, 32'd0);
      check("reset_busy", i, {31'd0, busy_w[i]}, 32'd0);
      check("reset_rdata", i, rdata_w[i], 32'd0);
    end

    // Release reset with a request already pending: the first rising edge must accept it.
    rstn = 1'b1;
    for (int k = 0; k < 16; k++) issue(1'b1, 32'(k * 4), $urandom, 4'hF, 1'b0);

    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    issue(1'b0, 32'h10, 32'd0, 4'h0, 1'b0);
    issue(1'b1, 32'h10, 32'h00AB0000, 4'h4, 1'b0);
    issue(1'b0, 32'h10, 32'd0, 4'h0, 1'b0);
    issue(1'b1, 32'h10, 32'h11223344, 4'h0, 1'b1);
    issue(1'b0, 32'h13, 32'd0, 4'h0, 1'b0);
    issue(1'b0, 32'h00001000, 32'd0, 4'h0, 1'b0);
    issue(1'b1, 32'h00001010, 32'hCAFEF00D, 4'hF, 1'b0);
    issue(1'b0, 32'h10, 32'd0, 4'h0, 1'b0);
    issue(1'b0, 32'h80000010, 32'd0, 4'h0, 1'b1);

    repeat (60) begin
      w   = 1'($urandom);
      oor = ($urandom_range(0, 5) == 0);
      idx = $urandom_range(0, 15);
      a   = 32'(idx * 4 + $urandom_range(0, 3));
      if (oor) a = a | (32'h1000 << $urandom_range(0, 19));
      issue(w, a, $urandom, 4'($urandom), 1'($urandom));
    end

    stream(14);

    // Reset during the wait phase: only the zero-wait instance has committed the write.
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF;
    mm[0][8] = 32'h12345678;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    req  = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check("midreset_ack", i, {31'd0, ack_w[i]}, 32'd0);
      check("midreset_err", i, {31'd0, err_w[i]}, 32'd0);
      check("midreset_busy", i, {31'd0, busy_w[i]}, 32'd0);
      check("midreset_rdata", i, rdata_w[i], 32'd0);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) last_rd[i] = 32'd0;
    rstn = 1'b1;
    issue(1'b1, 32'h30, $urandom, 4'hF, 1'b0);
    issue(1'b0, 32'h20, 32'd0, 4'h0, 1'b0);
    issue(1'b0, 32'h10, 32'd0, 4'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
